par2ser: RTL
============

Name: par2ser

Overview:
- Parallel-to-serial transmitter; the companion of ser2par on the same serial link.
- Accepts LENGTH-bit words over a valid/ready handshake and emits them one bit per enabled clock, with ovalid/olast framing.
- A one-word holding buffer allows back-to-back words to stream with no idle cycle between them.
- Sits in front of ser2par in the Shift memory library and is used for serial links and loopback tests.

Parameters:
- LENGTH, 8, word width in bits; legal range 2..64.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clock.
- enable  input  1  global clock-enable; when 0 all state freezes.
- direct  input  1  bit order, sampled with each word: 0 = MSB first, 1 = LSB first.
- ivalid  input  1  parallel word available.
- idata  input  LENGTH  parallel word.
- iready  output  1  word can be accepted this cycle.
- ovalid  output  1  odata carries a valid serial bit.
- odata  output  1  serial bit.
- olast  output  1  current bit is the final bit of its word.

Behaviour:
- Transfer rule: a word is accepted on a rising edge where ivalid=1 and iready=1.
- iready = reset & enable & !hfull. This is combinational from flops; iready does not depend on ivalid.
- State: shifter register sreg[LENGTH-1:0], per-word direction sdir, bit counter cnt (width clog2(LENGTH)), FSM {IDLE, SHIFT}, holding register hbuf, hdir, hfull.
- Reset (reset=0 at edge): FSM=IDLE, cnt=0, hfull=0, sreg=0, hbuf=0.
  - ovalid=0, odata=0, olast=0 from the next cycle on.
  - iready=0 while reset is low.
  - Reset wins over every other event, including mid-word; a partially sent word is discarded and no olast is emitted for it.
- enable=0: no accept, no shift, cnt/FSM/buffers hold. ovalid/odata/olast hold their values; the sink must qualify them with enable.
- Outputs:
  - ovalid = (FSM==SHIFT).
  - odata = sdir ? sreg[0] : sreg[LENGTH-1]. Forced to 0 when FSM==IDLE.
  - olast = ovalid & (cnt==LENGTH-1).
- Bit advance (enable=1, FSM=SHIFT): sreg shifts toward the output end (left for MSB-first, right for LSB-first), zero-fill; cnt++.
- End of word (enable=1, FSM=SHIFT, cnt==LENGTH-1):
  - if hfull: load sreg/sdir from hbuf/hdir, cnt=0, stay SHIFT, hfull=0.
  - else, if a word is accepted this same edge: load it directly (bypass), cnt=0, stay SHIFT.
  - else: FSM=IDLE.
- IDLE accept: the word loads directly into sreg with sdir=direct, cnt=0, FSM=SHIFT. The first bit is on odata the cycle after acceptance (latency 1).
- SHIFT accept when not at the last bit: the word goes to hbuf/hdir, hfull=1, so iready drops the next cycle.
- Simultaneous end of word + hbuf drain + new accept: cannot occur, because iready=0 while hfull=1.
- Throughput: continuous ivalid gives continuous ovalid, one word every LENGTH cycles, with no gap bits.
- direct changing while a word is held or shifting has no effect on that word.

Decomposition:
- Shared package par2ser_pkg:
  - FSM state typedef (IDLE, SHIFT).
  - function cnt_width(LENGTH) = clog2(LENGTH), minimum 1.
  - constants DIR_MSB=0, DIR_LSB=1; the same constants are reused by ser2par.
- One sub-module is natural: par2ser_hold, the single-entry holding buffer (hbuf/hdir/hfull with load/drain).
- The FSM, shifter and counter stay in the top module.

Test Plan (LENGTH=8):
- Reset: reset=0 for 2 cycles with ivalid=1 -> iready=0, ovalid=0, odata=0, olast=0; no word accepted.
- MSB-first: idata=8'hB5, direct=0, one accept -> ovalid high for exactly 8 cycles starting 1 cycle after the accept; odata=1,0,1,1,0,1,0,1; olast only on the 8th bit; then ovalid=0.
- LSB-first: idata=8'hB5, direct=1 -> odata=1,0,1,0,1,1,0,1.
- Back-to-back: 8'hD5 then 8'hBB with ivalid held high, direct=0 -> 16 consecutive ovalid bits 11010101_10111011 with no gap; iready=0 from the cycle after the second accept until the cycle after the buffer drains.
- Stall and mid-word reset:
  - enable=0 for 3 cycles mid-word -> outputs and bit position frozen; the sequence resumes intact.
  - reset=0 after bit 4 -> ovalid=0 next cycle; the next word starts cleanly from bit 0.
- Loopback: odata/ovalid drive ser2par (LENGTH=8, same direct); random words 8'h00, 8'hFF, 8'hA5, 8'h3C -> ser2par odata equals each sent word, with ovalid once per word.

Source files
------------

// File: rtl/par2ser_pkg.sv
// par2ser_pkg: definitions shared by the par2ser transmitter and its
// companion ser2par receiver on the same serial link.
//   state_t    - transmitter FSM encoding (IDLE, SHIFT)
//   cnt_width  - width of the bit counter for a given word length
//   DIR_MSB / DIR_LSB - bit-order encodings carried on the 'direct' input
package par2ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic DIR_MSB = 1'b0;
  localparam logic DIR_LSB = 1'b1;

  // Counter must index bits 0..length-1; never narrower than one bit.
  function automatic int cnt_width(input int length);
    int w;
    w = $clog2(length);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/par2ser_hold.sv
// par2ser_hold: single-entry holding buffer that parks the next word while
// the shifter is still busy, so consecutive words stream without a gap.
// Ports:
//   clock, reset (sync, active-low), enable (global clock-enable)
//   load      - capture word/dir and mark the entry full
//   drain     - entry consumed by the shifter; mark it empty
//   word, dir - incoming word and its bit order
//   buf_word, buf_dir, full - the held entry
module par2ser_hold #(
  parameter int LENGTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              load,
  input  logic              drain,
  input  logic [LENGTH-1:0] word,
  input  logic              dir,
  output logic [LENGTH-1:0] buf_word,
  output logic              buf_dir,
  output logic              full
);

  // load and drain are never asserted together: the top only accepts
  // words while the buffer is empty, and only drains it while full.
  always_ff @(posedge clock) begin
    if (!reset) begin
      buf_word <= '0;
      buf_dir  <= 1'b0;
      full     <= 1'b0;
    end else if (enable) begin
      if (load) begin
        buf_word <= word;
        buf_dir  <= dir;
        full     <= 1'b1;
      end else if (drain) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/par2ser.sv
// par2ser: parallel-to-serial transmitter. Accepts LENGTH-bit words on a
// valid/ready handshake and sends one bit per enabled clock, framed by
// ovalid/olast. A one-word holding buffer keeps back-to-back words gapless.
// Ports:
//   clock, reset (sync, active-low), enable (global clock-enable)
//   direct    - bit order for the word being accepted (0 MSB first, 1 LSB first)
//   ivalid, idata, iready - parallel word input handshake
//   ovalid, odata, olast  - serial output; olast marks a word's final bit
//   fsm_state - current FSM state, exposed for observation
//
// Handshake: a word transfers on a rising edge where ivalid=1 and iready=1.
// iready depends only on flops and reset/enable, never on ivalid, and
// ivalid may rise or fall at any time without a combinational path back.
module par2ser
  import par2ser_pkg::*;
#(
  parameter int LENGTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              direct,
  input  logic              ivalid,
  input  logic [LENGTH-1:0] idata,
  output logic              iready,
  output logic              ovalid,
  output logic              odata,
  output logic              olast,
  output state_t            fsm_state
);

  localparam int CW = cnt_width(LENGTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(LENGTH - 1);

  state_t            state, state_next;
  logic [LENGTH-1:0] sreg;
  logic              sdir;
  logic [CW-1:0]     cnt;

  logic [LENGTH-1:0] hbuf;
  logic              hdir;
  logic              hfull;

  logic accept;
  logic at_last;
  logic load_new;    // load sreg straight from idata/direct
  logic load_hold;   // load sreg from the holding buffer
  logic shift;       // advance one bit
  logic hold_load;   // park the accepted word in the holding buffer

  assign iready  = reset & enable & ~hfull;
  assign accept  = ivalid & iready;
  assign at_last = (cnt == LAST_CNT);

  always_comb begin
    state_next = state;
    load_new   = 1'b0;
    load_hold  = 1'b0;
    shift      = 1'b0;
    hold_load  = 1'b0;
    if (enable) begin
      case (state)
        IDLE: begin
          if (accept) begin
            load_new   = 1'b1;
            state_next = SHIFT;
          end
        end
        SHIFT: begin
          if (at_last) begin
            // Buffered word has priority; iready is low while it is full,
            // so a fresh accept cannot coincide with a drain.
            if (hfull) begin
              load_hold = 1'b1;
            end else if (accept) begin
              load_new = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end else begin
            shift     = 1'b1;
            hold_load = accept;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
      sdir  <= DIR_MSB;
    end else if (enable) begin
      state <= state_next;
      if (load_hold) begin
        sreg <= hbuf;
        sdir <= hdir;
        cnt  <= '0;
      end else if (load_new) begin
        sreg <= idata;
        sdir <= direct;
        cnt  <= '0;
      end else if (shift) begin
        // Move the next bit toward whichever end drives odata.
        sreg <= (sdir == DIR_LSB) ? {1'b0, sreg[LENGTH-1:1]}
                                  : {sreg[LENGTH-2:0], 1'b0};
        cnt  <= cnt + CW'(1);
      end else if (state_next == IDLE) begin
        cnt <= '0;
      end
    end
  end

  par2ser_hold #(.LENGTH(LENGTH)) u_hold (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .load     (hold_load),
    .drain    (load_hold),
    .word     (idata),
    .dir      (direct),
    .buf_word (hbuf),
    .buf_dir  (hdir),
    .full     (hfull)
  );

  assign ovalid    = (state == SHIFT);
  assign odata     = ovalid & ((sdir == DIR_LSB) ? sreg[0] : sreg[LENGTH-1]);
  assign olast     = ovalid & at_last;
  assign fsm_state = state;

endmodule
